// File: rtl/serial_arbiter.sv
// serial_arbiter: round-robin framer sharing one UART byte path among NUM_SRC sources.
// Ports: sclk/rstn clock and async active-low reset; srcValid/srcData/srcLast/srcReady
// per-source byte stream; uartReady/outByte/dataReady UART byte handshake; grant one-hot
// owner; busy frame in progress; frameDone/timeoutErr pulse when the checksum byte leaves.
module serial_arbiter #(
    parameter int         NUM_SRC   = 4,
    parameter int         MAX_LEN   = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 1000
) (
    input  logic                   sclk,
    input  logic                   rstn,
    input  logic [NUM_SRC-1:0]     srcValid,
    input  logic [8*NUM_SRC-1:0]   srcData,
    input  logic [NUM_SRC-1:0]     srcLast,
    output logic [NUM_SRC-1:0]     srcReady,
    input  logic                   uartReady,
    output logic [7:0]             outByte,
    output logic                   dataReady,
    output logic [NUM_SRC-1:0]     grant,
    output logic                   busy,
    output logic                   frameDone,
    output logic                   timeoutErr
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SYNC, ID, PAYLOAD, CKSUM} state_t;

    state_t         state, state_next;
    logic [1:0]     rst_sync;
    logic [2:0]     ptr, idx, pick, off;
    logic [3:0]     sum;
    logic [NUM_SRC-1:0] rot;
    logic           found;
    logic [7:0]     csum, cnt, cur_byte;
    logic [TW-1:0]  timer;
    logic           end_pending, aborted, cur_last, cur_valid;
    logic           run, req, uart_xfer, src_xfer, idle_tick, expire;

    assign run       = rst_sync[1];
    assign req       = run && |srcValid;
    assign uart_xfer = dataReady && uartReady;
    assign src_xfer  = state == PAYLOAD && !dataReady && cur_valid;
    assign idle_tick = state == PAYLOAD && !dataReady && !cur_valid;
    assign expire    = idle_tick && timer == TW'(TIMEOUT - 1);

    // Release of rstn is retimed so the first grant never races the reset edge.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) rst_sync <= 2'b00;
        else       rst_sync <= {rst_sync[0], 1'b1};
    end

    // Rotating the request vector by ptr turns round-robin into a find-first-set.
    always_comb begin
        rot   = NUM_SRC'({srcValid, srcValid} >> ptr);
        found = 1'b0;
        off   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = 3'(i);
            end
        end
        sum  = {1'b0, ptr} + {1'b0, off};
        pick = sum >= 4'(NUM_SRC) ? 3'(sum - 4'(NUM_SRC)) : sum[2:0];
    end

    always_comb begin
        cur_byte  = '0;
        cur_last  = 1'b0;
        cur_valid = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                cur_byte  = srcData[8*i +: 8];
                cur_last  = srcLast[i];
                cur_valid = srcValid[i];
            end
        end
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = SYNC;
            SYNC:    if (uart_xfer) state_next = ID;
            ID:      if (uart_xfer) state_next = PAYLOAD;
            PAYLOAD: if (expire || (uart_xfer && end_pending)) state_next = CKSUM;
            CKSUM:   if (uart_xfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        srcReady = (state == PAYLOAD && !dataReady) ? grant : '0;
        busy     = state != IDLE;
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            outByte     <= '0;
            dataReady   <= 1'b0;
            grant       <= '0;
            frameDone   <= 1'b0;
            timeoutErr  <= 1'b0;
            ptr         <= '0;
            idx         <= '0;
            csum        <= '0;
            cnt         <= '0;
            timer       <= '0;
            end_pending <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            frameDone  <= 1'b0;
            timeoutErr <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    grant     <= {{(NUM_SRC-1){1'b0}}, 1'b1} << pick;
                    idx       <= pick;
                    outByte   <= SYNC_BYTE;
                    dataReady <= 1'b1;
                end
                SYNC: if (uart_xfer) begin
                    outByte <= {5'b0, idx};
                    csum    <= {5'b0, idx};
                end
                ID: if (uart_xfer) begin
                    dataReady   <= 1'b0;
                    cnt         <= '0;
                    timer       <= '0;
                    end_pending <= 1'b0;
                    aborted     <= 1'b0;
                end
                PAYLOAD: begin
                    if (src_xfer) begin
                        outByte   <= cur_byte;
                        dataReady <= 1'b1;
                        csum      <= csum ^ cur_byte;
                        cnt       <= cnt + 8'd1;
                        timer     <= '0;
                        if (cur_last || cnt == 8'(MAX_LEN - 1)) end_pending <= 1'b1;
                    end else if (expire) begin
                        aborted   <= 1'b1;
                        outByte   <= ~csum;
                        dataReady <= 1'b1;
                    end else if (idle_tick) begin
                        timer <= timer + 1'b1;
                    end else if (uart_xfer) begin
                        if (end_pending) outByte <= csum;
                        else             dataReady <= 1'b0;
                    end
                end
                CKSUM: if (uart_xfer) begin
                    dataReady  <= 1'b0;
                    frameDone  <= 1'b1;
                    timeoutErr <= aborted;
                    ptr        <= idx == 3'(NUM_SRC - 1) ? 3'd0 : idx + 3'd1;
                    grant      <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_arbiter.sv
// tb_serial_arbiter: scoreboard bench for serial_arbiter with directed frame vectors.
module tb_serial_arbiter;
    typedef struct packed {
        logic [7:0] b;
        logic [3:0] g;
        logic       fin;
        logic       ab;
    } exp_t;

    logic        sclk = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  srcValid, srcLast, srcReady, grant;
    logic [31:0] srcData;
    logic        uartReady, dataReady, busy, frameDone, timeoutErr;
    logic [7:0]  outByte;

    exp_t        exp_q[$];
    logic [8:0]  sq[4][$];
    int          pass_n = 0;
    int          total_n = 0;
    logic        pend_done = 1'b0;
    logic        pend_ab = 1'b0;
    logic        mon_en = 1'b1;

    serial_arbiter dut (
        .sclk(sclk), .rstn(rstn), .srcValid(srcValid), .srcData(srcData),
        .srcLast(srcLast), .srcReady(srcReady), .uartReady(uartReady),
        .outByte(outByte), .dataReady(dataReady), .grant(grant), .busy(busy),
        .frameDone(frameDone), .timeoutErr(timeoutErr)
    );

    initial forever #5 sclk = ~sclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total_n++;
        if (act === exp_v) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    endtask

    task automatic send(input int s, input logic [127:0] d, input int n, input logic last);
        for (int i = 0; i < n; i++) sq[s].push_back({last && i == n - 1, d[8*(n-1-i) +: 8]});
    endtask

    task automatic expect_frame(input int s, input logic [127:0] d, input int n,
                                input logic [7:0] ck, input logic ab);
        logic [3:0] g;
        g = 4'b0001 << s;
        exp_q.push_back({8'hA5, g, 1'b0, 1'b0});
        exp_q.push_back({8'(s), g, 1'b0, 1'b0});
        for (int i = 0; i < n; i++) exp_q.push_back({d[8*(n-1-i) +: 8], g, 1'b0, 1'b0});
        exp_q.push_back({ck, g, 1'b1, ab});
    endtask

    task automatic drain(input string nm, input int budget);
        int c;
        c = 0;
        while ((exp_q.size() > 0 || pend_done) && c < budget) begin
            @(negedge sclk);
            c++;
        end
        if (c >= budget) begin
            total_n++;
            $display("FAIL %s: drain timed out with %0d bytes still expected", nm, exp_q.size());
            exp_q.delete();
            pend_done = 1'b0;
        end
        repeat (3) @(negedge sclk);
    endtask

    // Source driver: each source presents the head of its queue; a transfer pops it.
    initial begin : drv
        logic [3:0] xf;
        srcValid = '0;
        srcData  = '0;
        srcLast  = '0;
        forever begin
            @(negedge sclk);
            xf = srcValid & srcReady;
            @(posedge sclk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (xf[i] && sq[i].size() > 0) void'(sq[i].pop_front());
                srcValid[i]      = 1'b0;
                srcLast[i]       = 1'b0;
                srcData[8*i +: 8] = 8'h00;
                if (sq[i].size() > 0) begin
                    srcValid[i]       = 1'b1;
                    srcLast[i]        = sq[i][0][8];
                    srcData[8*i +: 8] = sq[i][0][7:0];
                end
            end
        end
    end

    // Monitor: every UART transfer pops one expected byte; frame end checks the pulses.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge sclk);
            if (pend_done) begin
                chk("frame_pulse", 32'({frameDone, timeoutErr}), 32'({1'b1, pend_ab}));
                pend_done = 1'b0;
            end else if (frameDone || timeoutErr) begin
                chk("stray_pulse", 32'({frameDone, timeoutErr}), 32'd0);
            end
            if (mon_en && dataReady && uartReady) begin
                if (exp_q.size() == 0) begin
                    total_n++;
                    $display("FAIL extra_byte: got %h expected no byte", outByte);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte", 32'(outByte), 32'(e.b));
                    chk("grant", 32'(grant), 32'(e.g));
                    if (e.fin) begin
                        pend_done = 1'b1;
                        pend_ab   = e.ab;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int c;
        uartReady = 1'b1;
        repeat (2) @(negedge sclk);
        chk("rst_data", 32'({outByte, dataReady}), 32'd0);
        chk("rst_ctrl", 32'({srcReady, grant, busy}), 32'd0);
        chk("rst_pulse", 32'({frameDone, timeoutErr}), 32'd0);
        @(posedge sclk);
        #1 rstn = 1'b1;
        repeat (3) @(posedge sclk);
        #1;

        expect_frame(0, 128'h010204, 3, 8'h07, 1'b0);
        send(0, 128'h010204, 3, 1'b1);
        drain("basic", 100);
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        expect_frame(1, 128'h1112, 2, 8'h02, 1'b0);
        expect_frame(3, 128'h31, 1, 8'h32, 1'b0);
        send(1, 128'h1112, 2, 1'b1);
        send(3, 128'h31, 1, 1'b1);
        drain("rr_a", 200);

        expect_frame(0, 128'h0506, 2, 8'h03, 1'b0);
        expect_frame(1, 128'h13, 1, 8'h12, 1'b0);
        send(1, 128'h13, 1, 1'b1);
        send(0, 128'h0506, 2, 1'b1);
        drain("rr_b", 200);

        expect_frame(2, 128'h10, 1, 8'hED, 1'b1);
        send(2, 128'h10, 1, 1'b0);
        drain("timeout", 1200);

        expect_frame(3, 128'h41, 1, 8'h42, 1'b0);
        expect_frame(0, 128'h40, 1, 8'h40, 1'b0);
        send(0, 128'h40, 1, 1'b1);
        send(3, 128'h41, 1, 1'b1);
        drain("ptr_after_to", 200);

        expect_frame(0, 128'h000102030405060708090A0B0C0D0E0F, 16, 8'h00, 1'b0);
        expect_frame(0, 128'h10111213, 4, 8'hFF, 1'b1);
        send(0, 128'h000102030405060708090A0B0C0D0E0F, 16, 1'b0);
        send(0, 128'h10111213, 4, 1'b0);
        drain("max_len", 1500);

        uartReady = 1'b0;
        expect_frame(1, 128'h50, 1, 8'h51, 1'b0);
        send(1, 128'h50, 1, 1'b1);
        c = 0;
        do begin
            @(negedge sclk);
            c++;
        end while (!dataReady && c < 20);
        chk("bp_sync_ready", 32'(dataReady), 32'd1);
        @(posedge sclk);
        #1 uartReady = 1'b1;
        @(posedge sclk);
        #1 uartReady = 1'b0;
        repeat (50) begin
            @(negedge sclk);
            chk("id_hold", 32'({dataReady, outByte, srcReady, timeoutErr}), 32'({1'b1, 8'h01, 4'b0000, 1'b0}));
        end
        @(posedge sclk);
        #1 uartReady = 1'b1;
        drain("backpressure", 200);

        mon_en = 1'b0;
        send(2, 128'h6061626364656667, 8, 1'b1);
        c = 0;
        do begin
            @(negedge sclk);
            c++;
        end while (!srcReady[2] && c < 30);
        chk("pre_rst_payload", 32'(srcReady), 32'b0100);
        repeat (3) @(negedge sclk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_data", 32'({outByte, dataReady}), 32'd0);
        chk("arst_ctrl", 32'({srcReady, grant, busy}), 32'd0);
        @(posedge sclk);
        #2;
        sq[2].delete();
        exp_q.delete();
        pend_done = 1'b0;
        repeat (2) @(posedge sclk);
        #1 rstn = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(posedge sclk);
        #1;
        expect_frame(3, 128'h70, 1, 8'h73, 1'b0);
        send(3, 128'h70, 1, 1'b1);
        drain("after_reset", 200);
        chk("end_grant", 32'(grant), 32'd0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
